// File: rtl/breath_if.sv
// Control and LED-drive bundle for the breathing sequencer.
// Master drives requests; slave reports state, duty and the pin.
interface breath_if #(
  parameter int DUTY_W = 7
);
  logic              start;
  logic              stop;
  logic              loop;
  logic              busy;
  logic [DUTY_W-1:0] duty;
  logic              pwm_out;
  logic              cycle_done;

  modport master (
    output start, stop, loop,
    input  busy, duty, pwm_out, cycle_done
  );

  modport slave (
    input  start, stop, loop,
    output busy, duty, pwm_out, cycle_done
  );
endinterface

// File: rtl/breath_sequencer.sv
// LED breathing sequencer: ramp up, hold, ramp down, hold off.
// Owns the shared PWM counter and the registered LED comparator.
module breath_sequencer #(
  parameter int PWM_STEPS    = 100,
  parameter int STEP_PERIODS = 5000,
  parameter int DUTY_INC     = 1,
  parameter int DUTY_MAX     = 99,
  parameter int HOLD_STEPS   = 50,
  parameter int DUTY_W       = 7
) (
  input logic     clk,
  input logic     rst_n,
  breath_if.slave bus
);

  localparam int CW  = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int PW  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HW  = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam int DXW = DUTY_W + 1;

  localparam logic [CW-1:0]  PWM_LAST  = CW'(PWM_STEPS - 1);
  localparam logic [PW-1:0]  PER_LAST  = PW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [DXW-1:0] INC_X     = DXW'(DUTY_INC);
  localparam logic [DXW-1:0] MAX_X     = DXW'(DUTY_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HI,
    RAMP_DOWN,
    HOLD_LO
  } state_e;

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0]     per_q, per_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              pwm_q, pwm_d;
  logic              cd_q, cd_d;

  logic              busy;
  logic              tick;
  logic [DXW-1:0]    up_x;
  logic [DUTY_W-1:0] up_duty;
  logic [DUTY_W-1:0] dn_duty;

  assign busy = (state_q != IDLE);
  assign tick = (pwm_cnt_q == PWM_LAST) &&
                (per_q == PER_LAST);

  // Saturating steps done one bit wider so DUTY_MAX near 2**DUTY_W cannot wrap
  assign up_x    = {1'b0, duty_q} + INC_X;
  assign up_duty = (up_x >= MAX_X) ? MAX_X[DUTY_W-1:0]
                                   : up_x[DUTY_W-1:0];
  assign dn_duty = ({1'b0, duty_q} > INC_X)
                 ? duty_q - INC_X[DUTY_W-1:0]
                 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      per_q     <= '0;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      pwm_q     <= 1'b0;
      cd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      per_q     <= per_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      pwm_q     <= pwm_d;
      cd_q      <= cd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    pwm_cnt_d = pwm_cnt_q;
    per_d     = per_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    pwm_d     = 1'b0;
    cd_d      = 1'b0;

    if (busy) begin
      if (pwm_cnt_q == PWM_LAST) begin
        pwm_cnt_d = '0;
        per_d     = (per_q == PER_LAST) ? '0
                                        : per_q + PW'(1);
      end else begin
        pwm_cnt_d = pwm_cnt_q + CW'(1);
      end
      if (bus.stop) pend_d = 1'b1;
      pwm_d = (32'(pwm_cnt_q) < 32'(duty_q));
    end

    unique case (state_q)
      IDLE: begin
        duty_d    = '0;
        pwm_cnt_d = '0;
        per_d     = '0;
        hold_d    = '0;
        pend_d    = 1'b0;
        if (bus.start && !bus.stop) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (tick) begin
          if (pend_q) begin
            state_d = RAMP_DOWN;
          end else begin
            duty_d = up_duty;
            if (32'(up_duty) == DUTY_MAX) begin
              state_d = HOLD_HI;
              hold_d  = '0;
            end
          end
        end
      end
      HOLD_HI: begin
        if (tick) begin
          if (pend_q || hold_q == HOLD_LAST) begin
            state_d = RAMP_DOWN;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          duty_d = dn_duty;
          if (dn_duty == '0) begin
            state_d = HOLD_LO;
            hold_d  = '0;
          end
        end
      end
      HOLD_LO: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            cd_d   = 1'b1;
            hold_d = '0;
            duty_d = '0;
            if (bus.loop && !pend_q) begin
              state_d = RAMP_UP;
            end else begin
              state_d = IDLE;
              pend_d  = 1'b0;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = busy;
  assign bus.duty       = duty_q;
  assign bus.pwm_out    = pwm_q;
  assign bus.cycle_done = cd_q;

endmodule
